// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : Controller and byte buffer for a UART receive deserialiser.
//            Sequences the deserialiser reset and enable, captures each
//            completed frame exactly once, and checks its start, stop and
//            parity bits. Good bytes go into a show-ahead FIFO that the core
//            reads with a valid/ready handshake. Error flags are sticky and
//            drive irq.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                          baud_clk,
  input  logic                          reset,
  input  logic                          rx_enable,
  input  logic                          fifo_flush,
  output logic                          sipo_reset,
  input  logic                          sipo_rx_flag,
  input  logic [10:0]                   sipo_data,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun_err,
  input  logic                          err_clr,
  output logic                          irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_IDLE  = 2'd1,
    S_CHECK = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            flag_q;
  logic [10:0]     frame_q;

  logic            capture;
  logic            push;
  logic            set_frame_err;
  logic            set_parity_err;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            rx_rise;
  logic            bad_framing;
  logic            bad_parity;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            set_overrun;

  // Frame-complete is detected on the first cycle the flag is seen high,
  // so a flag held for many cycles yields a single capture.
  assign rx_rise     = sipo_rx_flag & ~flag_q;
  assign bad_framing = frame_q[0] | ~frame_q[10];
  assign bad_parity  = PARITY_EN && ((^frame_q[9:1]) != PARITY_ODD);

  // State, flag history and captured frame.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state   <= S_OFF;
      flag_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      state  <= state_next;
      flag_q <= sipo_rx_flag;
      if (capture) begin
        frame_q <= sipo_data;
      end
    end
  end

  // Next state, deserialiser reset and per-frame decisions. Dropping
  // rx_enable takes priority everywhere, so a frame in S_CHECK is abandoned
  // without a push or an error flag.
  always_comb begin
    state_next     = state;
    sipo_reset     = 1'b0;
    capture        = 1'b0;
    push           = 1'b0;
    set_frame_err  = 1'b0;
    set_parity_err = 1'b0;
    if (state == S_OFF) begin
      sipo_reset = 1'b1;
    end
    if (!rx_enable) begin
      state_next = S_OFF;
    end else begin
      case (state)
        S_OFF: begin
          state_next = S_IDLE;
        end
        S_IDLE: begin
          if (rx_rise) begin
            capture    = 1'b1;
            state_next = S_CHECK;
          end
        end
        S_CHECK: begin
          if (bad_framing) begin
            set_frame_err = 1'b1;
          end else if (bad_parity) begin
            set_parity_err = 1'b1;
          end else begin
            push = 1'b1;
          end
          state_next = S_DRAIN;
        end
        S_DRAIN: begin
          if (!sipo_rx_flag) begin
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_OFF;
        end
      endcase
    end
  end

  assign full     = (count == FULL_COUNT);
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
  assign push_ok  = push & (~full | pop);
  // A flush discards the incoming byte silently, so it never overruns.
  assign set_overrun = push & full & ~pop & ~fifo_flush;

  assign rd_data    = mem[rd_ptr];
  assign fifo_count = count;

  // FIFO storage, pointers and occupancy; flush beats push and pop.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= frame_q[8:1];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky error flags; a same-cycle set outranks err_clr.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (set_frame_err) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (set_parity_err) begin
        parity_err <= 1'b1;
      end else if (err_clr) begin
        parity_err <= 1'b0;
      end
      if (set_overrun) begin
        overrun_err <= 1'b1;
      end else if (err_clr) begin
        overrun_err <= 1'b0;
      end
    end
  end

  assign irq = rd_valid | frame_err | parity_err | overrun_err;

endmodule
`default_nettype wire
